// File: rtl/oam_dma_if.sv
// CPU-bus / OAM write-port bundle for the sprite DMA engine.
interface oam_dma_if #(
    parameter int unsigned OAM_AW = 8
);
    logic              reg_wr_en;
    logic [7:0]        reg_data;
    logic [7:0]        oam_base;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              mem_re;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_rdata;
    logic [OAM_AW-1:0] oam_addr;
    logic              oam_we;
    logic [7:0]        oam_data;

    modport master (
        input  reg_wr_en, reg_data, oam_base, mem_rdata,
        output cpu_halt, busy, done, mem_re, mem_addr, oam_addr, oam_we, oam_data
    );

    modport slave (
        output reg_wr_en, reg_data, oam_base, mem_rdata,
        input  cpu_halt, busy, done, mem_re, mem_addr, oam_addr, oam_we, oam_data
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies one 256-byte CPU page into OAM,
// alternating get/put CPU cycles for 513/514-cycle NES timing.
module oam_dma #(
    parameter int unsigned OAM_AW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_clk_en,
    oam_dma_if.master    bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PAGE_W = 8;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic                cyc_odd_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [7:0]          base_q, base_d;
    logic [7:0]          data_q, data_d;
    logic                halt_q, halt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [OAM_AW-1:0]   oam_addr_q, oam_addr_d;
    logic                oam_we_q, oam_we_d;

    // State, datapath and registered outputs advance only on CPU-cycle enables;
    // done is a single master-clock pulse so it clears on the next clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cyc_odd_q  <= 1'b0;
            cnt_q      <= '0;
            page_q     <= '0;
            base_q     <= '0;
            data_q     <= '0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            oam_addr_q <= '0;
            oam_we_q   <= 1'b0;
        end else begin
            done_q <= cpu_clk_en & done_d;
            if (cpu_clk_en) begin
                state_q    <= state_d;
                cyc_odd_q  <= ~cyc_odd_q;
                cnt_q      <= cnt_d;
                page_q     <= page_d;
                base_q     <= base_d;
                data_q     <= data_d;
                halt_q     <= halt_d;
                busy_q     <= busy_d;
                mem_re_q   <= mem_re_d;
                mem_addr_q <= mem_addr_d;
                oam_addr_q <= oam_addr_d;
                oam_we_q   <= oam_we_d;
            end
        end
    end

    // Next state plus next-cycle outputs, so every output is a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        page_d     = page_q;
        base_d     = base_q;
        data_d     = data_q;
        done_d     = 1'b0;
        mem_addr_d = mem_addr_q;
        oam_addr_d = oam_addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.reg_wr_en) begin
                    page_d  = bus.reg_data;
                    base_d  = bus.oam_base;
                    cnt_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT:  state_d = cyc_odd_q ? S_READ : S_ALIGN;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                data_d  = bus.mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(255)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        halt_d   = (state_d != S_IDLE);
        busy_d   = (state_d != S_IDLE);
        mem_re_d = (state_d == S_READ);
        oam_we_d = (state_d == S_WRITE);
        if (mem_re_d) begin
            mem_addr_d = {page_d, cnt_d};
        end
        if (oam_we_d) begin
            oam_addr_d = OAM_AW'(base_d + cnt_d);
        end
    end

    assign bus.cpu_halt = halt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.oam_addr = oam_addr_q;
    assign bus.oam_we   = oam_we_q;
    assign bus.oam_data = data_q;
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: table of transfers plus reset/strobe corner sequences.
module tb_oam_dma;
    localparam int unsigned OAM_AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_clk_en = 1'b0;
    logic hold_off = 1'b0;
    int unsigned div = 0;
    logic par;
    int done_cnt = 0;
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] oam_mem [256];

    typedef struct {
        logic [7:0] page;
        logic [7:0] base;
        logic       odd;
        logic       strobe;
        int         exp_cycles;
        int         exp_first;
    } vec_t;
    vec_t vt [5];

    oam_dma_if #(.OAM_AW(OAM_AW)) bus ();
    oam_dma #(.OAM_AW(OAM_AW)) dut (.clk(clk), .rst_n(rst_n), .cpu_clk_en(cpu_clk_en), .bus(bus));

    always #5 clk = ~clk;

    // CPU memory image; page 0x02 gives byte a[7:0]^0xA5, other pages differ.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction
    assign bus.mem_rdata = mem_byte(bus.mem_addr);

    initial forever begin
        @(negedge clk);
        cpu_clk_en = (div == 3) && !hold_off;
        div = (div + 1) % 4;
    end

    // Expected get/put parity and count of done pulses.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) par <= 1'b0;
        else if (cpu_clk_en) par <= ~par;
    always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic en_step();
        do @(posedge clk); while (!cpu_clk_en);
        #1;
    endtask

    task automatic run_transfer(input vec_t v, input int abort_after);
        int halted, first_rd, rd_idx, wr_cnt, bad_rd, bad_oam, guard, d0;
        logic [7:0] idx;
        logic [7:0] exp_oam [256];
        bit aborted;
        halted = 0; first_rd = 0; rd_idx = 0; wr_cnt = 0; bad_rd = 0; aborted = 0;
        for (int i = 0; i < 256; i++) exp_oam[i] = oam_mem[i];
        for (int i = 0; i < 256; i++) begin
            if (abort_after == 0 || i < abort_after) begin
                idx = v.base + 8'(i);
                exp_oam[idx] = mem_byte({v.page, 8'(i)});
            end
        end
        guard = 0;
        while (par != v.odd && guard < 4) begin en_step(); guard++; end
        d0 = done_cnt;
        bus.reg_data  = v.page;
        bus.oam_base  = v.base;
        bus.reg_wr_en = 1'b1;
        en_step();
        bus.reg_wr_en = 1'b0;
        bus.oam_base  = ~v.base;
        chk("halt_rise", 32'(bus.cpu_halt), 32'd1);
        while (bus.cpu_halt && halted < 600) begin
            halted++;
            if (bus.mem_re) begin
                if (first_rd == 0) first_rd = halted;
                if (bus.mem_addr !== {v.page, 8'(rd_idx)}) bad_rd++;
                rd_idx++;
            end
            if (bus.oam_we) begin
                oam_mem[bus.oam_addr] = bus.oam_data;
                wr_cnt++;
            end
            if (abort_after != 0 && wr_cnt == abort_after) begin
                aborted = 1;
                break;
            end
            bus.reg_data  = 8'h05;
            bus.reg_wr_en = v.strobe && (halted == 50 || (wr_cnt == 256 && bus.oam_we));
            en_step();
        end
        bus.reg_wr_en = 1'b0;
        if (aborted) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_halt", 32'(bus.cpu_halt), 32'd0);
            chk("abort_busy", 32'(bus.busy), 32'd0);
            chk("abort_mem_re", 32'(bus.mem_re), 32'd0);
            chk("abort_oam_we", 32'(bus.oam_we), 32'd0);
            chk("abort_oam_addr", 32'(bus.oam_addr), 32'd0);
            chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        end else begin
            chk("done_hi", 32'(bus.done), 32'd1);
            @(posedge clk); #1;
            chk("done_lo", 32'(bus.done), 32'd0);
            chk("done_count", 32'(done_cnt - d0), 32'd1);
            chk("halt_cycles", 32'(halted), 32'(v.exp_cycles));
            chk("first_read", 32'(first_rd), 32'(v.exp_first));
            chk("read_count", 32'(rd_idx), 32'd256);
            chk("write_count", 32'(wr_cnt), 32'd256);
            chk("read_addr_errs", 32'(bad_rd), 32'd0);
            en_step(); en_step();
            chk("no_restart", 32'(bus.cpu_halt), 32'd0);
        end
        bad_oam = 0;
        for (int i = 0; i < 256; i++) if (oam_mem[i] !== exp_oam[i]) bad_oam++;
        chk("oam_image_errs", 32'(bad_oam), 32'd0);
    endtask

    initial begin
        vec_t mid;
        vt[0] = '{page: 8'h02, base: 8'h00, odd: 1'b0, strobe: 1'b0, exp_cycles: 513, exp_first: 2};
        vt[1] = '{page: 8'h02, base: 8'h00, odd: 1'b1, strobe: 1'b0, exp_cycles: 514, exp_first: 3};
        vt[2] = '{page: 8'h07, base: 8'hFC, odd: 1'b0, strobe: 1'b0, exp_cycles: 513, exp_first: 2};
        vt[3] = '{page: 8'h07, base: 8'hFC, odd: 1'b1, strobe: 1'b1, exp_cycles: 514, exp_first: 3};
        vt[4] = '{page: 8'h11, base: 8'h80, odd: 1'b0, strobe: 1'b1, exp_cycles: 513, exp_first: 2};
        mid   = '{page: 8'h03, base: 8'h00, odd: 1'b0, strobe: 1'b0, exp_cycles: 513, exp_first: 2};
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

        // Reset with random inputs: every output low.
        bus.reg_wr_en = 1'($urandom);
        bus.reg_data  = 8'($urandom);
        bus.oam_base  = 8'($urandom);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_halt", 32'(bus.cpu_halt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_oam_addr", 32'(bus.oam_addr), 32'd0);
        chk("rst_oam_we", 32'(bus.oam_we), 32'd0);
        chk("rst_oam_data", 32'(bus.oam_data), 32'd0);
        bus.reg_wr_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        en_step(); en_step();
        chk("idle_halt", 32'(bus.cpu_halt), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_transfer(vt[i], 0);
            if (i == 2) begin
                chk("wrap_byte0", 32'(oam_mem[8'hFC]), 32'h0A0);
                chk("wrap_byte4", 32'(oam_mem[8'h00]), 32'h0A4);
                chk("wrap_byte255", 32'(oam_mem[8'hFB]), 32'h05F);
            end
        end

        // Reset after 100 writes, then a fresh transfer.
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h3C;
        run_transfer(mid, 100);
        @(negedge clk) rst_n = 1'b1;
        en_step();
        run_transfer(vt[0], 0);

        // Strobe while cpu_clk_en is held low must not start a transfer.
        hold_off = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.reg_data  = 8'h09;
        bus.reg_wr_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.reg_wr_en = 1'b0;
        hold_off = 1'b0;
        en_step(); en_step();
        chk("gated_strobe_halt", 32'(bus.cpu_halt), 32'd0);
        chk("gated_strobe_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
